// File: rtl/display_scan_if.sv
// Signal bundle between a display scan controller and its host / digit driver.
// The host owns data, load, enable and blank_mask; the controller owns the scan outputs.
interface display_scan_if #(
    parameter int unsigned DIGITS = 8
);
    logic [4*DIGITS-1:0] data;
    logic                load;
    logic                enable;
    logic [DIGITS-1:0]   blank_mask;
    logic [3:0]          digit;
    logic [DIGITS-1:0]   sel;
    logic                frame;
    logic                pending;

    modport master (
        output data, load, enable, blank_mask,
        input  digit, sel, frame, pending
    );

    modport slave (
        input  data, load, enable, blank_mask,
        output digit, sel, frame, pending
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one nibble per slot, blanking before each
// digit, double-buffered value committed only at frame boundaries.
module display_scan_ctrl #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned BLANK  = 16
) (
    input logic           clk,
    input logic           rst_n,
    display_scan_if.slave bus
);
    localparam int unsigned IW = $clog2(DIGITS);
    localparam int unsigned PW = $clog2(DIV);
    localparam int unsigned DW = 4 * DIGITS;

    localparam logic [IW-1:0] IdxMax   = IW'(DIGITS - 1);
    localparam logic [PW-1:0] DivMax   = PW'(DIV - 1);
    localparam logic [PW-1:0] BlankMax = PW'(BLANK - 1);

    typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [IW-1:0]   index_q, index_d;
    logic [DW-1:0]   shadow_q, shadow_d;
    logic [DW-1:0]   active_q, active_d;
    logic            pending_q, pending_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [3:0]      digit_q, digit_d;
    logic            frame_q, frame_d;
    logic            commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            presc_q <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            index_q <= index_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        index_d = index_q;
        commit  = 1'b0;
        frame_d = 1'b0;
        if (!bus.enable) begin
            state_d = StIdle;
            presc_d = '0;
            index_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StBlank;
                    presc_d = '0;
                    index_d = '0;
                    commit  = 1'b1;
                end
                StBlank: begin
                    presc_d = presc_q + PW'(1);
                    if (presc_q == BlankMax) state_d = StShow;
                end
                StShow: begin
                    if (presc_q == DivMax) begin
                        presc_d = '0;
                        state_d = StBlank;
                        if (index_q == IdxMax) begin
                            index_d = '0;
                            frame_d = 1'b1;
                            commit  = 1'b1;
                        end else begin
                            index_d = index_q + IW'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs decode the next state so they line up with the state register.
    always_comb begin
        shadow_d  = bus.load ? bus.data : shadow_q;
        active_d  = (commit && pending_q) ? shadow_q : active_q;
        pending_d = bus.load ? 1'b1 : (commit ? 1'b0 : pending_q);
        sel_d     = '1;
        digit_d   = '0;
        if (state_d != StIdle) digit_d = active_d[{index_d, 2'b00} +: 4];
        if (state_d == StShow && !bus.blank_mask[index_d]) sel_d[index_d] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            sel_q     <= '1;
            digit_q   <= '0;
            frame_q   <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            digit_q   <= digit_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.digit   = digit_q;
    assign bus.frame   = frame_q;
    assign bus.pending = pending_q;
endmodule
